mem_port_arbiter: RTL and testbench

- Shares the single external memory port between two requesters: instruction fetch (I, read-only) and the load/store unit (D, read/write).
- Sits between fetch/ld_st_unit and the memory controller.
- Uses the same level-request / done-pulse protocol on every side: a requester holds read or write until it sees done.
- Data side has priority, with an anti-starvation limit for fetch and a lock that keeps a CSWAP read-modify-write atomic.

---
 rtl/mem_port_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch (I) and LSU (D).
// D has priority, bounded by a fetch starvation limit; d_lock holds D for CSWAP.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   i_*               fetch side: address, read level, readdata, done pulse
//   d_*               LSU side: address, datasize, read/write levels,
//                     writedata, lock, readdata, done pulse
//   m_*               memory side: address, datasize, read/write levels,
//                     writedata, readdata, done pulse
//   grant             owner: 00 none, 01 I, 10 D
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] i_address,
  input  logic        i_read,
  output logic [63:0] i_readdata,
  output logic        i_done,
  input  logic [63:0] d_address,
  input  logic [1:0]  d_datasize,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [63:0] d_writedata,
  input  logic        d_lock,
  output logic [63:0] d_readdata,
  output logic        d_done,
  output logic [63:0] m_address,
  output logic [1:0]  m_datasize,
  output logic        m_read,
  output logic        m_write,
  output logic [63:0] m_writedata,
  input  logic [63:0] m_readdata,
  input  logic        m_done,
  output logic [1:0]  grant
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GNT_I = 2'd1,
    S_GNT_D = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] starve_cnt;
  logic [CNT_W-1:0] cnt_nxt;

  logic d_req;
  logic starved;

  assign d_req   = d_read | d_write;
  assign starved = (starve_cnt >= LIMIT);

  // readdata is only meaningful in the done cycle
  assign i_readdata = m_readdata;
  assign d_readdata = m_readdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = starve_cnt;
    unique case (state)
      S_IDLE: begin
        if (d_req && (!i_read || !starved))
          state_nxt = S_GNT_D;
        else if (i_read)
          state_nxt = S_GNT_I;
      end
      S_GNT_I: begin
        // dropped request aborts; a same-cycle m_done is discarded
        if (!i_read) begin
          state_nxt = S_IDLE;
        end else if (m_done) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end
      end
      S_GNT_D: begin
        if (!d_req) begin
          state_nxt = S_IDLE;
        end else if (m_done) begin
          if (i_read && !starved)
            cnt_nxt = starve_cnt + ONE;
          // lock keeps the port: no idle gap for I to slip in
          if (!d_lock)
            state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    grant       = 2'b00;
    m_address   = '0;
    m_datasize  = 2'd0;
    m_read      = 1'b0;
    m_write     = 1'b0;
    m_writedata = '0;
    i_done      = 1'b0;
    d_done      = 1'b0;
    unique case (state)
      S_IDLE: begin
        grant = 2'b00;
      end
      S_GNT_I: begin
        grant      = 2'b01;
        m_address  = i_address;
        m_datasize = 2'd3;
        m_read     = i_read;
        i_done     = m_done & i_read;
      end
      S_GNT_D: begin
        grant       = 2'b10;
        m_address   = d_address;
        m_datasize  = d_datasize;
        m_writedata = d_writedata;
        m_read      = d_read;
        m_write     = d_write & ~d_read;
        d_done      = m_done & d_req;
      end
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed cycle-by-cycle checks of mem_port_arbiter.
// Inputs change just after posedge; outputs are sampled on negedge.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] i_address;
  logic        i_read;
  logic [63:0] i_readdata;
  logic        i_done;
  logic [63:0] d_address;
  logic [1:0]  d_datasize;
  logic        d_read;
  logic        d_write;
  logic [63:0] d_writedata;
  logic        d_lock;
  logic [63:0] d_readdata;
  logic        d_done;
  logic [63:0] m_address;
  logic [1:0]  m_datasize;
  logic        m_read;
  logic        m_write;
  logic [63:0] m_writedata;
  logic [63:0] m_readdata;
  logic        m_done;
  logic [1:0]  grant;

  int n_run  = 0;
  int n_fail = 0;

  mem_port_arbiter #(
    .STARVE_LIMIT(4),
    .CNT_W(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .i_address(i_address),
    .i_read(i_read),
    .i_readdata(i_readdata),
    .i_done(i_done),
    .d_address(d_address),
    .d_datasize(d_datasize),
    .d_read(d_read),
    .d_write(d_write),
    .d_writedata(d_writedata),
    .d_lock(d_lock),
    .d_readdata(d_readdata),
    .d_done(d_done),
    .m_address(m_address),
    .m_datasize(m_datasize),
    .m_read(m_read),
    .m_write(m_write),
    .m_writedata(m_writedata),
    .m_readdata(m_readdata),
    .m_done(m_done),
    .grant(grant)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
    chk("done_excl", 64'(i_done & d_done), 64'd0);
    chk("idle_done", 64'((grant == 2'b00) & (i_done | d_done)), 64'd0);
  endtask

  initial begin
    reset       = 1'b1;
    i_address   = '0;
    i_read      = 1'b0;
    d_address   = '0;
    d_datasize  = 2'd0;
    d_read      = 1'b0;
    d_write     = 1'b0;
    d_writedata = '0;
    d_lock      = 1'b0;
    m_readdata  = '0;
    m_done      = 1'b0;

    nxt();
    nxt();
    smp();
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_mread", 64'(m_read), 64'd0);
    chk("rst_mwrite", 64'(m_write), 64'd0);
    chk("rst_cnt", 64'(dut.starve_cnt), 64'd0);

    // lone fetch, memory answers on the third m_read cycle
    nxt();
    reset     = 1'b0;
    i_read    = 1'b1;
    i_address = 64'h100;
    smp();
    chk("f_g0", 64'(grant), 64'd0);
    chk("f_mr0", 64'(m_read), 64'd0);
    nxt();
    smp();
    chk("f_g1", 64'(grant), 64'd1);
    chk("f_mr1", 64'(m_read), 64'd1);
    chk("f_addr", m_address, 64'h100);
    chk("f_size", 64'(m_datasize), 64'd3);
    chk("f_mw", 64'(m_write), 64'd0);
    chk("f_id1", 64'(i_done), 64'd0);
    nxt();
    smp();
    chk("f_id2", 64'(i_done), 64'd0);
    nxt();
    m_done     = 1'b1;
    m_readdata = 64'hDEADBEEF;
    smp();
    chk("f_id3", 64'(i_done), 64'd1);
    chk("f_rd", i_readdata, 64'hDEADBEEF);
    nxt();
    m_done = 1'b0;
    i_read = 1'b0;
    smp();
    chk("f_g2", 64'(grant), 64'd0);
    chk("f_id4", 64'(i_done), 64'd0);
    chk("f_addr0", m_address, 64'd0);

    // simultaneous requests: D first, one bubble, then I
    nxt();
    i_read     = 1'b1;
    i_address  = 64'h180;
    d_read     = 1'b1;
    d_address  = 64'h200;
    d_datasize = 2'd1;
    smp();
    chk("s_g0", 64'(grant), 64'd0);
    nxt();
    smp();
    chk("s_g1", 64'(grant), 64'd2);
    chk("s_mr", 64'(m_read), 64'd1);
    chk("s_addr", m_address, 64'h200);
    chk("s_size", 64'(m_datasize), 64'd1);
    nxt();
    m_done     = 1'b1;
    m_readdata = 64'h55;
    smp();
    chk("s_dd", 64'(d_done), 64'd1);
    chk("s_id", 64'(i_done), 64'd0);
    chk("s_drd", d_readdata, 64'h55);
    nxt();
    m_done = 1'b0;
    d_read = 1'b0;
    smp();
    chk("s_bub", 64'(grant), 64'd0);
    chk("s_bub_mr", 64'(m_read), 64'd0);
    nxt();
    smp();
    chk("s_gi", 64'(grant), 64'd1);
    chk("s_iaddr", m_address, 64'h180);
    nxt();
    m_done     = 1'b1;
    m_readdata = 64'h66;
    smp();
    chk("s_idn", 64'(i_done), 64'd1);
    chk("s_ddn", 64'(d_done), 64'd0);
    nxt();
    m_done = 1'b0;
    i_read = 1'b0;
    smp();
    chk("s_end", 64'(grant), 64'd0);

    // starvation: D continuous, I pending
    nxt();
    i_read     = 1'b1;
    i_address  = 64'h400;
    d_read     = 1'b1;
    d_address  = 64'h500;
    d_datasize = 2'd3;
    for (int k = 0; k < 4; k++) begin
      smp();
      chk("st_idle", 64'(grant), 64'd0);
      nxt();
      m_done     = 1'b1;
      m_readdata = 64'(k);
      smp();
      chk("st_gd", 64'(grant), 64'd2);
      chk("st_dd", 64'(d_done), 64'd1);
      nxt();
      m_done = 1'b0;
    end
    smp();
    chk("st_idle4", 64'(grant), 64'd0);
    chk("st_cnt4", 64'(dut.starve_cnt), 64'd4);
    nxt();
    m_done = 1'b1;
    smp();
    chk("st_gi", 64'(grant), 64'd1);
    chk("st_idn", 64'(i_done), 64'd1);
    chk("st_ddn", 64'(d_done), 64'd0);
    nxt();
    m_done = 1'b0;
    i_read = 1'b0;
    smp();
    chk("st_g0", 64'(grant), 64'd0);
    chk("st_cnt0", 64'(dut.starve_cnt), 64'd0);
    nxt();
    m_done = 1'b1;
    smp();
    chk("st_resume", 64'(grant), 64'd2);
    chk("st_rdd", 64'(d_done), 64'd1);
    nxt();
    m_done = 1'b0;
    d_read = 1'b0;
    smp();
    chk("st_end", 64'(grant), 64'd0);

    // CSWAP lock: read then write with no bubble, I waits
    nxt();
    i_read    = 1'b1;
    i_address = 64'h600;
    d_read    = 1'b1;
    d_lock    = 1'b1;
    d_address = 64'h700;
    smp();
    chk("l_g0", 64'(grant), 64'd0);
    nxt();
    m_done     = 1'b1;
    m_readdata = 64'hA5;
    smp();
    chk("l_g1", 64'(grant), 64'd2);
    chk("l_dd1", 64'(d_done), 64'd1);
    chk("l_mr", 64'(m_read), 64'd1);
    nxt();
    m_done      = 1'b0;
    d_read      = 1'b0;
    d_write     = 1'b1;
    d_lock      = 1'b0;
    d_writedata = 64'hBEEF;
    d_datasize  = 2'd2;
    smp();
    chk("l_g2", 64'(grant), 64'd2);
    chk("l_mw", 64'(m_write), 64'd1);
    chk("l_mr0", 64'(m_read), 64'd0);
    chk("l_wd", m_writedata, 64'hBEEF);
    chk("l_size", 64'(m_datasize), 64'd2);
    nxt();
    m_done = 1'b1;
    smp();
    chk("l_dd2", 64'(d_done), 64'd1);
    chk("l_g3", 64'(grant), 64'd2);
    nxt();
    m_done  = 1'b0;
    d_write = 1'b0;
    smp();
    chk("l_bub", 64'(grant), 64'd0);
    nxt();
    smp();
    chk("l_gi", 64'(grant), 64'd1);
    chk("l_cnt", 64'(dut.starve_cnt), 64'd2);
    nxt();
    m_done = 1'b1;
    smp();
    chk("l_idn", 64'(i_done), 64'd1);
    nxt();
    m_done = 1'b0;
    i_read = 1'b0;
    smp();
    chk("l_end", 64'(grant), 64'd0);

    // read wins over write, then abort with m_done in abort cycle
    nxt();
    d_read      = 1'b1;
    d_write     = 1'b1;
    d_writedata = 64'h1234;
    smp();
    chk("a_g0", 64'(grant), 64'd0);
    chk("a_mr0", 64'(m_read), 64'd0);
    chk("a_mw0", 64'(m_write), 64'd0);
    nxt();
    smp();
    chk("a_g1", 64'(grant), 64'd2);
    chk("a_mr1", 64'(m_read), 64'd1);
    chk("a_mw1", 64'(m_write), 64'd0);
    nxt();
    d_read  = 1'b0;
    d_write = 1'b0;
    m_done  = 1'b1;
    smp();
    chk("a_mr2", 64'(m_read), 64'd0);
    chk("a_mw2", 64'(m_write), 64'd0);
    chk("a_dd", 64'(d_done), 64'd0);
    nxt();
    m_done = 1'b0;
    smp();
    chk("a_g2", 64'(grant), 64'd0);

    // spurious m_done in idle
    nxt();
    m_done = 1'b1;
    smp();
    chk("sp_g", 64'(grant), 64'd0);
    chk("sp_id", 64'(i_done), 64'd0);
    chk("sp_dd", 64'(d_done), 64'd0);

    // reset while fetch granted with counter nonzero
    nxt();
    m_done = 1'b0;
    d_read = 1'b1;
    i_read = 1'b1;
    smp();
    chk("r_g0", 64'(grant), 64'd0);
    nxt();
    m_done = 1'b1;
    smp();
    chk("r_dd", 64'(d_done), 64'd1);
    nxt();
    m_done = 1'b0;
    d_read = 1'b0;
    smp();
    chk("r_bub", 64'(grant), 64'd0);
    nxt();
    smp();
    chk("r_gi", 64'(grant), 64'd1);
    chk("r_mr1", 64'(m_read), 64'd1);
    chk("r_cnt1", 64'(dut.starve_cnt), 64'd1);
    nxt();
    reset = 1'b1;
    smp();
    nxt();
    reset  = 1'b0;
    i_read = 1'b0;
    smp();
    chk("r_g", 64'(grant), 64'd0);
    chk("r_mr", 64'(m_read), 64'd0);
    chk("r_cnt", 64'(dut.starve_cnt), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
